// File: rtl/demux_rr_ctrl.sv
// Round-robin scheduler driving the select lines of a 1x4 demux.
// Define DEMUX_CNT_EN to add the per-channel delivery counters on cnt_all.
module demux_rr_ctrl #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       en_mask,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             S1,
  output logic             S0,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]      cnt_all
`endif
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] d_q, d_d;

  logic       deliver;
  logic       accept;
  logic [1:0] base;
  logic [1:0] pick;

  assign deliver  = (state_q == HOLD) && out_ready[sel_q];
  assign in_ready = (|en_mask) && ((state_q == IDLE) || deliver);
  assign accept   = in_valid && in_ready;

  // A word leaving this cycle moves the pointer before the next search.
  assign base = deliver ? sel_q : ptr_q;

  always_comb begin
    logic       found;
    logic [1:0] c;
    pick  = base;
    found = 1'b0;
    c     = base;
    for (int k = 1; k <= 4; k++) begin
      c = base + 2'(k);
      if (!found && en_mask[c]) begin
        pick  = c;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    d_d     = d_q;
    if (deliver) begin
      ptr_d   = sel_q;
      state_d = IDLE;
    end
    if (accept) begin
      sel_d   = pick;
      d_d     = in_data;
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      d_q     <= d_d;
    end
  end

  assign S1        = sel_q[1];
  assign S0        = sel_q[0];
  assign D         = d_q;
  assign out_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else if (deliver) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 8'd1;
    end
  end

  assign cnt_all = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
